sobel_kernel: RTL and testbench

SOBEL_KERNEL -- requirements
Module: sobel_kernel

---
 rtl/sobel_pkg.sv | 32 +++
 rtl/sobel_if.sv | 33 +++
 rtl/sobel_out_fifo.sv | 56 +++++
 rtl/sobel_kernel.sv | 103 ++++++++++
 tb/tb_sobel_kernel.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared constants for the Sobel edge kernel.
//   DEFAULT_PIXEL_WIDTH  default pixel / magnitude width
//   P0..P8               pixel slot indices inside the packed 3x3 window
//   PSUM_WIDTH           width of one unsigned partial sum (p + 2p + p)
//   GRAD_WIDTH           width of a signed gradient (difference of two partial sums)
package sobel_pkg;

    localparam int DEFAULT_PIXEL_WIDTH = 8;

    localparam int P0 = 0;
    localparam int P1 = 1;
    localparam int P2 = 2;
    localparam int P3 = 3;
    localparam int P4 = 4;
    localparam int P5 = 5;
    localparam int P6 = 6;
    localparam int P7 = 7;
    localparam int P8 = 8;

    localparam int PSUM_WIDTH = DEFAULT_PIXEL_WIDTH + 2;
    localparam int GRAD_WIDTH = PSUM_WIDTH + 1;

    // a + 2b + c of three pixels never exceeds 4*(2^pw - 1), so two extra bits suffice
    function automatic int psum_width(int pw);
        return pw + 2;
    endfunction

    function automatic int grad_width(int pw);
        return pw + 3;
    endfunction

endpackage

// File: rtl/sobel_if.sv
// sobel_if: window input / result output bundle of the Sobel kernel.
//   window_valid, window_in, threshold  producer -> kernel
//   out_valid, out_mag, out_bin         kernel -> consumer (FWFT head)
//   out_ready                           consumer -> kernel
//   overflow / clr_overflow             sticky drop flag and its clear
// The kernel uses the slave modport; the driving environment uses master.
interface sobel_if
    import sobel_pkg::*;
#(
    parameter int PIXEL_WIDTH = DEFAULT_PIXEL_WIDTH
);

    logic                     window_valid;
    logic [9*PIXEL_WIDTH-1:0] window_in;
    logic [PIXEL_WIDTH-1:0]   threshold;
    logic                     out_valid;
    logic                     out_ready;
    logic [PIXEL_WIDTH-1:0]   out_mag;
    logic                     out_bin;
    logic                     overflow;
    logic                     clr_overflow;

    modport master (
        output window_valid, window_in, threshold, out_ready, clr_overflow,
        input  out_valid, out_mag, out_bin, overflow
    );

    modport slave (
        input  window_valid, window_in, threshold, out_ready, clr_overflow,
        output out_valid, out_mag, out_bin, overflow
    );

endinterface

// File: rtl/sobel_out_fifo.sv
// sobel_out_fifo: first-word-fall-through result FIFO.
//   clk, rst     clock, asynchronous active-high reset
//   push, din    write request and data; dropped when full unless a pop happens in the same cycle
//   full         occupancy equals DEPTH
//   pop, dout    read request and head data (valid whenever empty is low)
//   empty        occupancy is zero
// DEPTH must be a power of two so the pointers wrap naturally.
module sobel_out_fifo #(
    parameter int DW    = 9,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    output logic          full,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = cnt == '0;
    assign full    = cnt == CW'(DEPTH);
    assign pop_ok  = pop & ~empty;
    // a pop frees the slot in the same cycle, so a full FIFO still accepts a write then
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            rd_ptr <= pop_ok ? rd_ptr + AW'(1) : rd_ptr;
            wr_ptr <= push_ok ? wr_ptr + AW'(1) : wr_ptr;
            cnt    <= cnt + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sobel_kernel.sv
// sobel_kernel: 3-stage Sobel gradient pipeline with saturated magnitude,
// threshold flag and an output FIFO.
//   clk, rst  clock, asynchronous active-high reset
//   bus       sobel_if.slave: window_valid/window_in/threshold in,
//             out_valid/out_ready/out_mag/out_bin FWFT result port,
//             overflow (sticky drop flag) / clr_overflow
// Stage 1: four partial sums, stage 2: |Gx| and |Gy|, stage 3: magnitude and flag,
// then the result is pushed into the FIFO on the following edge.
module sobel_kernel
    import sobel_pkg::*;
#(
    parameter int PIXEL_WIDTH = DEFAULT_PIXEL_WIDTH,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic   clk,
    input  logic   rst,
    sobel_if.slave bus
);

    localparam int          SW      = psum_width(PIXEL_WIDTH);
    localparam logic [SW:0] MAX_MAG = {{(SW + 1 - PIXEL_WIDTH){1'b0}}, {PIXEL_WIDTH{1'b1}}};

    logic [PIXEL_WIDTH-1:0] p [9];
    logic                   v1, v2, v3;
    logic [SW-1:0]          gx_pos, gx_neg, gy_pos, gy_neg;
    logic [SW-1:0]          abs_gx, abs_gy;
    logic [SW:0]            mag_sum;
    logic [PIXEL_WIDTH-1:0] mag3;
    logic                   bin3;
    logic [PIXEL_WIDTH:0]   head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic                   drop;
    logic                   ovf;

    function automatic logic [SW-1:0] tri_sum(input logic [PIXEL_WIDTH-1:0] a, b, c);
        return SW'(a) + (SW'(b) << 1) + SW'(c);
    endfunction

    always_comb begin
        for (int k = 0; k < 9; k++)
            p[k] = bus.window_in[k*PIXEL_WIDTH +: PIXEL_WIDTH];
    end

    assign mag_sum = {1'b0, abs_gx} + {1'b0, abs_gy};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            v1 <= bus.window_valid;
            v2 <= v1;
            v3 <= v2;
        end
    end

    // Datapath carries no reset; the valid chain alone qualifies it.
    always_ff @(posedge clk) begin
        gx_pos <= tri_sum(p[P2], p[P5], p[P8]);
        gx_neg <= tri_sum(p[P0], p[P3], p[P6]);
        gy_pos <= tri_sum(p[P6], p[P7], p[P8]);
        gy_neg <= tri_sum(p[P0], p[P1], p[P2]);
        // magnitude of the signed difference, taken without forming the signed value
        abs_gx <= gx_pos >= gx_neg ? gx_pos - gx_neg : gx_neg - gx_pos;
        abs_gy <= gy_pos >= gy_neg ? gy_pos - gy_neg : gy_neg - gy_pos;
        mag3   <= mag_sum > MAX_MAG ? {PIXEL_WIDTH{1'b1}} : mag_sum[PIXEL_WIDTH-1:0];
        bin3   <= (mag_sum > MAX_MAG ? {PIXEL_WIDTH{1'b1}} : mag_sum[PIXEL_WIDTH-1:0]) >= bus.threshold;
    end

    assign pop  = bus.out_ready & ~fifo_empty;
    assign drop = v3 & fifo_full & ~pop;

    sobel_out_fifo #(
        .DW    (PIXEL_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (v3),
        .din   ({bin3, mag3}),
        .full  (fifo_full),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty)
    );

    // a drop in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf <= 1'b0;
        else
            ovf <= drop ? 1'b1 : bus.clr_overflow ? 1'b0 : ovf;
    end

    assign bus.out_valid = ~fifo_empty;
    assign bus.out_mag   = fifo_empty ? '0 : head[PIXEL_WIDTH-1:0];
    assign bus.out_bin   = ~fifo_empty & head[PIXEL_WIDTH];
    assign bus.overflow  = ovf;

endmodule

// File: tb/tb_sobel_kernel.sv
// tb_sobel_kernel: directed self-checking bench for sobel_kernel.
module tb_sobel_kernel;
    import sobel_pkg::*;

    localparam int PW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    sobel_if #(.PIXEL_WIDTH(PW)) bus ();

    sobel_kernel #(
        .PIXEL_WIDTH (PW),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9*PW-1:0] p2_win(input int k);
        logic [9*PW-1:0] w;
        w = '0;
        w[P2*PW +: PW] = PW'(k);
        return w;
    endfunction

    // one window into an idle pipeline, result consumed immediately (out_ready high)
    task automatic run_one(input string tag, input logic [9*PW-1:0] w, input logic [PW-1:0] thr,
                           input logic [PW-1:0] exp_mag, input logic exp_bin);
        bus.threshold    = thr;
        bus.window_in    = w;
        bus.window_valid = 1'b1;
        tick();
        bus.window_valid = 1'b0;
        check({tag, ":lat0"}, 32'(bus.out_valid), 0);
        tick();
        check({tag, ":lat1"}, 32'(bus.out_valid), 0);
        tick();
        check({tag, ":lat2"}, 32'(bus.out_valid), 0);
        tick();
        check({tag, ":valid"}, 32'(bus.out_valid), 1);
        check({tag, ":mag"}, 32'(bus.out_mag), 32'(exp_mag));
        check({tag, ":bin"}, 32'(bus.out_bin), 32'(exp_bin));
        tick();
        check({tag, ":once"}, 32'(bus.out_valid), 0);
        check({tag, ":mag0"}, 32'(bus.out_mag), 0);
    endtask

    initial begin
        bus.window_valid = 1'b0;
        bus.window_in    = '0;
        bus.threshold    = '0;
        bus.out_ready    = 1'b1;
        bus.clr_overflow = 1'b0;
        repeat (2) tick();
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_mag", 32'(bus.out_mag), 0);
        check("rst_bin", 32'(bus.out_bin), 0);
        check("rst_ovf", 32'(bus.overflow), 0);
        rst = 1'b0;
        tick();

        run_one("flat", {9{8'h80}}, 8'd1, 8'h00, 1'b0);
        run_one("vert", {3{8'hFF, 8'h37, 8'h00}}, 8'd128, 8'hFF, 1'b1);
        run_one("thr40", {3{8'd10, 8'd0, 8'd0}}, 8'd40, 8'd40, 1'b1);
        run_one("thr41", {3{8'd10, 8'd0, 8'd0}}, 8'd41, 8'd40, 1'b0);
        run_one("diag", {8'd20, 64'd0}, 8'd1, 8'd40, 1'b1);
        run_one("gy", {8'h10, 8'h10, 8'h10, 48'd0}, 8'd100, 8'd64, 1'b0);

        // full FIFO with a pop and a write on the same edge: both succeed, no overflow
        bus.threshold = '0;
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            bus.window_in    = p2_win(k);
            bus.window_valid = 1'b1;
            tick();
        end
        bus.window_valid = 1'b0;
        repeat (2) tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("fullpop_ovf", 32'(bus.overflow), 0);
        check("fullpop_head", 32'(bus.out_mag), 4);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check("fullpop_drain", 32'(bus.out_mag), 32'(4 + 2 * j));
            tick();
        end
        check("fullpop_empty", 32'(bus.out_valid), 0);

        // six windows against a stalled consumer: four held, two dropped
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            bus.window_in    = p2_win(k);
            bus.window_valid = 1'b1;
            tick();
        end
        bus.window_valid = 1'b0;
        tick();
        check("ovf_before5", 32'(bus.overflow), 0);
        check("ovf_head", 32'(bus.out_mag), 2);
        tick();
        check("ovf_on5", 32'(bus.overflow), 1);
        tick();
        check("ovf_sticky", 32'(bus.overflow), 1);
        check("ovf_head_stable", 32'(bus.out_mag), 2);
        check("ovf_head_bin", 32'(bus.out_bin), 1);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check("ovf_drain", 32'(bus.out_mag), 32'(2 + 2 * j));
            tick();
        end
        check("ovf_drained", 32'(bus.out_valid), 0);

        // reset with 3 windows in flight and 2 results queued (overflow still set)
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            bus.window_in    = p2_win(k);
            bus.window_valid = 1'b1;
            tick();
        end
        bus.window_valid = 1'b0;
        check("pre_rst_valid", 32'(bus.out_valid), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 0);
        check("mid_rst_ovf", 32'(bus.overflow), 0);
        check("mid_rst_mag", 32'(bus.out_mag), 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (6) tick();
        check("post_rst_stale", 32'(bus.out_valid), 0);
        bus.out_ready = 1'b1;
        run_one("post_rst", p2_win(3), 8'd0, 8'd6, 1'b1);

        // clr_overflow clears the sticky flag
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            bus.window_in    = p2_win(k);
            bus.window_valid = 1'b1;
            tick();
        end
        bus.window_valid = 1'b0;
        repeat (3) tick();
        check("clr_set", 32'(bus.overflow), 1);
        bus.clr_overflow = 1'b1;
        tick();
        bus.clr_overflow = 1'b0;
        check("clr_done", 32'(bus.overflow), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
